// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu_pkg
//  Brief   : Shared opcodes, NOP constants, FSM state codes and the op
//            decoder used by the MEM-stage load/store unit.
//  Revision: 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

  // Memory-access operation codes carried on ex_aluop
  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_ADD_OP = 8'b00100000;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY     = 3'd1,
    ST_DONE     = 3'd2,
    ST_DONE_ERR = 3'd3,
    ST_DRAIN    = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_signed;
    acc_size_e size;
  } op_info_t;

  // Classify an aluop into access kind, direction, size and signedness
  function automatic op_info_t decode_op(input logic [7:0] op);
    op_info_t r;
    r.is_mem    = 1'b1;
    r.is_load   = 1'b1;
    r.is_signed = 1'b0;
    r.size      = SZ_WORD;
    case (op)
      EXE_LB_OP:  begin r.size = SZ_BYTE; r.is_signed = 1'b1; end
      EXE_LBU_OP: r.size = SZ_BYTE;
      EXE_LH_OP:  begin r.size = SZ_HALF; r.is_signed = 1'b1; end
      EXE_LHU_OP: r.size = SZ_HALF;
      EXE_LW_OP:  r.size = SZ_WORD;
      EXE_SB_OP:  begin r.size = SZ_BYTE; r.is_load = 1'b0; end
      EXE_SH_OP:  begin r.size = SZ_HALF; r.is_load = 1'b0; end
      EXE_SW_OP:  r.is_load = 1'b0;
      default:    begin r.is_mem = 1'b0; r.is_load = 1'b0; end
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu_align
//  Brief   : Combinational lane logic: byte enables, store-data replication,
//            load extraction/extension and misalignment detection.
//            Lanes are big-endian: addr[1:0]=00 is bits [31:24].
//  Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        is_load_o,
  output logic        addr_err_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  op_info_t    info;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign info      = decode_op(aluop_i);
  assign is_mem_o  = info.is_mem;
  assign is_load_o = info.is_load;

  // Halfwords need bit 0 clear, words need both low bits clear
  assign addr_err_o = info.is_mem &&
                      (((info.size == SZ_HALF) && addr_lo_i[0]) ||
                       ((info.size == SZ_WORD) && (addr_lo_i != 2'b00)));

  // Byte-lane enables from access size and low address bits
  always_comb begin
    sel_o = 4'b0000;
    if (info.is_mem) begin
      case (info.size)
        SZ_BYTE: begin
          case (addr_lo_i)
            2'b00:   sel_o = 4'b1000;
            2'b01:   sel_o = 4'b0100;
            2'b10:   sel_o = 4'b0010;
            default: sel_o = 4'b0001;
          endcase
        end
        SZ_HALF: sel_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        default: sel_o = 4'b1111;
      endcase
    end
  end

  // Store data is replicated so every enabled lane carries the operand
  always_comb begin
    wdata_o = ZERO_WORD;
    if (info.is_mem && !info.is_load) begin
      case (info.size)
        SZ_BYTE: wdata_o = {4{reg2_i[7:0]}};
        SZ_HALF: wdata_o = {2{reg2_i[15:0]}};
        default: wdata_o = reg2_i;
      endcase
    end
  end

  // Pick the addressed lane out of the captured read word
  always_comb begin
    case (addr_lo_i)
      2'b00:   lane_b = rdata_i[31:24];
      2'b01:   lane_b = rdata_i[23:16];
      2'b10:   lane_b = rdata_i[15:8];
      default: lane_b = rdata_i[7:0];
    endcase
    lane_h = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  // Sign- or zero-extend sub-word loads; whole words pass unchanged
  always_comb begin
    ldata_o = rdata_i;
    if (info.is_load) begin
      case (info.size)
        SZ_BYTE: ldata_o = {{24{info.is_signed & lane_b[7]}}, lane_b};
        SZ_HALF: ldata_o = {{16{info.is_signed & lane_h[15]}}, lane_h};
        default: ldata_o = rdata_i;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module  : mem_lsu
//  Brief   : MEM-stage load/store unit. Non-memory ops pass straight to
//            mem_wb; loads/stores run one req/ack data-bus transaction and
//            hold the pipeline via stallreq until it completes, aborts on
//            timeout, or drains after a flush.
//  Revision: 1.0 - initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_whilo_i,
  input  logic [31:0] ex_hi_i,
  input  logic [31:0] ex_lo_i,
  input  logic [7:0]  ex_aluop_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_reg2_i,
  input  logic        mem_stall_i,
  input  logic        mem_flush_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_whilo_o,
  output logic [31:0] mem_hi_o,
  output logic [31:0] mem_lo_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  output logic        stallreq_o,
  output logic        addr_err_o,
  output logic        bus_err_o
);

  // Counter only needs to reach BUS_TIMEOUT-1; zero disables the abort
  localparam int              CNT_W      = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (BUS_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             req_q;
  logic             bus_err_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdata_q;

  logic             is_mem;
  logic             is_load;
  logic             mis_al;
  logic [3:0]       lane_sel;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;
  logic             start;

  mem_lsu_align u_align (
    .aluop_i    (ex_aluop_i),
    .addr_lo_i  (ex_mem_addr_i[1:0]),
    .reg2_i     (ex_reg2_i),
    .rdata_i    (rdata_q),
    .is_mem_o   (is_mem),
    .is_load_o  (is_load),
    .addr_err_o (mis_al),
    .sel_o      (lane_sel),
    .wdata_o    (st_data),
    .ldata_o    (ld_data)
  );

  assign start = is_mem && !mis_al && !mem_flush_i;

  // Transaction FSM; bus controls are captured at launch so a flush that
  // changes ex_* cannot disturb a request still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= ZERO_WORD;
      req_q     <= 1'b0;
      bus_err_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= ZERO_WORD;
      sel_q     <= 4'b0000;
      wdata_q   <= ZERO_WORD;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            we_q    <= !is_load;
            addr_q  <= {ex_mem_addr_i[31:2], 2'b00};
            sel_q   <= lane_sel;
            wdata_q <= st_data;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (dbus_ack_i) begin
            req_q <= 1'b0;
            if (mem_flush_i) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= dbus_rdata_i;
              state_q <= ST_DONE;
            end
          end else if (mem_flush_i) begin
            state_q <= ST_DRAIN;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE_ERR;
          end
        end
        ST_DONE, ST_DONE_ERR: begin
          if (!mem_stall_i || mem_flush_i) state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (dbus_ack_i) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Stall while a request is being launched, in flight, or draining
  always_comb begin
    stallreq_o = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE:  stallreq_o = start;
        ST_BUSY:  stallreq_o = 1'b1;
        ST_DRAIN: stallreq_o = 1'b1;
        default:  stallreq_o = 1'b0;
      endcase
    end
  end

  // Result to mem_wb: passthrough for ALU ops, load data on completion
  always_comb begin
    mem_wd_o    = ex_wd_i;
    mem_wreg_o  = ex_wreg_i;
    mem_wdata_o = ex_wdata_i;
    mem_whilo_o = ex_whilo_i;
    mem_hi_o    = ex_hi_i;
    mem_lo_o    = ex_lo_i;
    if (rst) begin
      mem_wd_o    = NOP_REG_ADDR;
      mem_wreg_o  = 1'b0;
      mem_wdata_o = ZERO_WORD;
      mem_whilo_o = 1'b0;
      mem_hi_o    = ZERO_WORD;
      mem_lo_o    = ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem) mem_wreg_o = 1'b0;
        end
        ST_DONE: begin
          mem_wreg_o  = ex_wreg_i & is_load;
          mem_wdata_o = ld_data;
        end
        ST_DONE_ERR: begin
          mem_wreg_o  = 1'b0;
          mem_wdata_o = ZERO_WORD;
        end
        default: begin
          mem_wreg_o  = 1'b0;
          mem_whilo_o = 1'b0;
        end
      endcase
    end
  end

  assign addr_err_o   = !rst && mis_al;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_sel_o   = sel_q;
  assign dbus_wdata_o = wdata_q;
  assign bus_err_o    = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_lsu
//  Brief   : Scoreboard bench for mem_lsu. The driver pushes expected
//            retirements and bus requests; monitors pop and compare them
//            when the DUT retires an op or raises a new request.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic        mem_stall;
  logic        mem_flush;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [31:0] mem_wdata_o;
  logic        mem_whilo_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        stallreq_o;
  logic        addr_err_o;
  logic        bus_err_o;

  mem_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_wd_i       (ex_wd),
    .ex_wreg_i     (ex_wreg),
    .ex_wdata_i    (ex_wdata),
    .ex_whilo_i    (ex_whilo),
    .ex_hi_i       (ex_hi),
    .ex_lo_i       (ex_lo),
    .ex_aluop_i    (ex_aluop),
    .ex_mem_addr_i (ex_mem_addr),
    .ex_reg2_i     (ex_reg2),
    .mem_stall_i   (mem_stall),
    .mem_flush_i   (mem_flush),
    .dbus_rdata_i  (dbus_rdata),
    .dbus_ack_i    (dbus_ack),
    .mem_wd_o      (mem_wd_o),
    .mem_wreg_o    (mem_wreg_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_whilo_o   (mem_whilo_o),
    .mem_hi_o      (mem_hi_o),
    .mem_lo_o      (mem_lo_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_sel_o    (dbus_sel_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .stallreq_o    (stallreq_o),
    .addr_err_o    (addr_err_o),
    .bus_err_o     (bus_err_o)
  );

  typedef struct {
    string       nm;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        aerr;
  } ret_t;

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  ret_t ret_q[$];
  bus_t bus_q[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   berr_cnt = 0;
  logic tb_valid = 1'b0;
  int   ack_after = 0;
  logic [31:0] rd_val = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  // Bus slave: ack on the ack_after-th cycle of a held request (0 = never)
  initial begin
    int req_cycles;
    req_cycles = 0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      if (dbus_req_o && !rst) begin
        req_cycles++;
        if (ack_after != 0 && req_cycles == ack_after) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rd_val;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Retirement monitor: an issued op retires on the first unstalled cycle
  initial begin
    ret_t e;
    forever begin
      @(negedge clk);
      if (tb_valid && !rst && !stallreq_o) begin
        if (ret_q.size() == 0) chk("retire_unexpected", 32'd1, 32'd0);
        else begin
          e = ret_q.pop_front();
          chk({e.nm, "_wd"},   {27'd0, mem_wd_o}, {27'd0, e.wd});
          chk({e.nm, "_wreg"}, {31'd0, mem_wreg_o}, {31'd0, e.wreg});
          chk({e.nm, "_aerr"}, {31'd0, addr_err_o}, {31'd0, e.aerr});
          if (e.chk_data) chk({e.nm, "_wdata"}, mem_wdata_o, e.wdata);
        end
      end
    end
  end

  // Bus monitor: compare request fields when a new request rises
  initial begin
    bus_t b;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dbus_req_o && !prev) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
        else begin
          b = bus_q.pop_front();
          chk({b.nm, "_we"},    {31'd0, dbus_we_o}, {31'd0, b.we});
          chk({b.nm, "_addr"},  dbus_addr_o, b.addr);
          chk({b.nm, "_sel"},   {28'd0, dbus_sel_o}, {28'd0, b.sel});
          chk({b.nm, "_bwdata"}, dbus_wdata_o, b.wdata);
        end
      end
      if (bus_err_o) berr_cnt++;
      prev = dbus_req_o;
    end
  end

  task automatic set_ex(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0;
  endtask

  task automatic push_bus(input string nm, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
    bus_t b;
    b.nm = nm; b.we = we; b.addr = addr; b.sel = sel; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Issue one op, wait for it to retire and check stall/request/error counts
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg_in,
                        input logic [31:0] wdata_in, input logic [31:0] rd, input int ack_n,
                        input logic exp_wreg, input logic [31:0] exp_wdata, input logic chk_data,
                        input logic exp_aerr, input logic has_bus, input logic exp_we,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_sel,
                        input logic [31:0] exp_bw, input int exp_stall, input int exp_req,
                        input int exp_berr);
    ret_t e;
    int stall_n, req_n, b0;
    bit done;
    @(posedge clk); #1;
    set_ex(op, addr, reg2, wd, wreg_in, wdata_in);
    rd_val = rd; ack_after = ack_n;
    e.nm = nm; e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_wdata;
    e.chk_data = chk_data; e.aerr = exp_aerr;
    ret_q.push_back(e);
    if (has_bus) push_bus(nm, exp_we, exp_baddr, exp_sel, exp_bw);
    b0 = berr_cnt;
    tb_valid = 1'b1;
    stall_n = 0; req_n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (dbus_req_o) req_n++;
      if (!stallreq_o) done = 1;
      else stall_n++;
    end
    chk({nm, "_retired"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    set_ex(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    chk({nm, "_stall_cycles"}, stall_n, exp_stall);
    chk({nm, "_req_cycles"}, req_n, exp_req);
    chk({nm, "_bus_err_pulses"}, berr_cnt - b0, exp_berr);
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; mem_flush = 1'b0;
    // ALU op present during reset must be masked to NOP
    set_ex(EXE_ADD_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wd",       {27'd0, mem_wd_o}, 32'd0);
    chk("rst_wreg",     {31'd0, mem_wreg_o}, 32'd0);
    chk("rst_wdata",    mem_wdata_o, 32'd0);
    chk("rst_dbus_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_bus_err",  {31'd0, bus_err_o}, 32'd0);
    chk("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_ex(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

    //     name   op          addr          reg2          wd    wr   wdata        rdata         ack ewr  ewdata       cd   ae   bus  we   baddr         sel      bwdata       st rq be
    run_op("add", EXE_ADD_OP, 32'h0,        32'h0,        5'd5, 1'b1, 32'h1234,   32'h0,        0, 1'b1, 32'h1234,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,       0, 0, 0);
    run_op("lb",  EXE_LB_OP,  32'h101,      32'h0,        5'd7, 1'b1, 32'h0,      32'h00800000, 3, 1'b1, 32'hFFFFFF80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,     4'b0100, 32'h0,       4, 3, 0);
    run_op("lbu", EXE_LBU_OP, 32'h101,      32'h0,        5'd7, 1'b1, 32'h0,      32'h00800000, 3, 1'b1, 32'h00000080, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,     4'b0100, 32'h0,       4, 3, 0);
    run_op("sh",  EXE_SH_OP,  32'h102,      32'hABCD,     5'd2, 1'b1, 32'h0,      32'h0,        2, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h100,     4'b0011, 32'hABCDABCD, 3, 2, 0);
    run_op("lw_mis", EXE_LW_OP, 32'h102,    32'h0,        5'd4, 1'b1, 32'h0,      32'h0,        1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,       0, 0, 0);
    run_op("lw_to", EXE_LW_OP,  32'h300,    32'h0,        5'd4, 1'b1, 32'h0,      32'h0,        0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b0, 32'h300,     4'b1111, 32'h0,       5, 4, 1);
    run_op("lw",  EXE_LW_OP,  32'h104,      32'h0,        5'd8, 1'b1, 32'h0,      32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104,     4'b1111, 32'h0,       2, 1, 0);
    run_op("lh",  EXE_LH_OP,  32'h102,      32'h0,        5'd9, 1'b1, 32'h0,      32'h1234F00D, 2, 1'b1, 32'hFFFFF00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,     4'b0011, 32'h0,       3, 2, 0);
    run_op("lhu", EXE_LHU_OP, 32'h100,      32'h0,        5'd9, 1'b1, 32'h0,      32'h80015555, 1, 1'b1, 32'h00008001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100,     4'b1100, 32'h0,       2, 1, 0);
    run_op("sb",  EXE_SB_OP,  32'h103,      32'h12345678, 5'd1, 1'b0, 32'h0,      32'h0,        1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 32'h100,     4'b0001, 32'h78787878, 2, 1, 0);
    run_op("lh_mis", EXE_LH_OP, 32'h101,    32'h0,        5'd3, 1'b1, 32'h0,      32'h0,        1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       4'b0000, 32'h0,       0, 0, 0);

    // Flush in BUSY, ack two cycles later: request drains, then idle
    @(posedge clk); #1;
    set_ex(EXE_LW_OP, 32'h200, 32'h0, 5'd6, 1'b1, 32'h0);
    rd_val = 32'h11111111; ack_after = 3;
    push_bus("flush", 1'b0, 32'h200, 4'b1111, 32'h0);
    @(negedge clk);
    chk("flush_launch_stall", {31'd0, stallreq_o}, 32'd1);
    @(posedge clk); #1;
    mem_flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_wreg", {31'd0, mem_wreg_o}, 32'd0);
    @(posedge clk); #1;
    mem_flush = 1'b0;
    set_ex(EXE_ADD_OP, 32'h0, 32'h0, 5'd10, 1'b1, 32'h77);
    @(negedge clk);
    chk("drain_req",   {31'd0, dbus_req_o}, 32'd1);
    chk("drain_stall", {31'd0, stallreq_o}, 32'd1);
    chk("drain_wreg",  {31'd0, mem_wreg_o}, 32'd0);
    chk("drain_addr",  dbus_addr_o, 32'h200);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_ack_req", {31'd0, dbus_req_o}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_done_req",   {31'd0, dbus_req_o}, 32'd0);
    chk("drain_done_stall", {31'd0, stallreq_o}, 32'd0);
    chk("drain_done_wreg",  {31'd0, mem_wreg_o}, 32'd1);

    // Ack and flush in the same cycle: transaction ends, data discarded
    @(posedge clk); #1;
    set_ex(EXE_LW_OP, 32'h210, 32'h0, 5'd6, 1'b1, 32'h0);
    rd_val = 32'h99999999; ack_after = 1;
    push_bus("ackflush", 1'b0, 32'h210, 4'b1111, 32'h0);
    @(posedge clk); #1;
    mem_flush = 1'b1;
    @(negedge clk);
    chk("ackflush_req", {31'd0, dbus_req_o}, 32'd1);
    @(posedge clk); #1;
    mem_flush = 1'b0;
    set_ex(EXE_ADD_OP, 32'h0, 32'h0, 5'd9, 1'b1, 32'h55);
    @(negedge clk);
    chk("ackflush_idle_req",   {31'd0, dbus_req_o}, 32'd0);
    chk("ackflush_idle_stall", {31'd0, stallreq_o}, 32'd0);
    chk("ackflush_idle_wreg",  {31'd0, mem_wreg_o}, 32'd1);
    chk("ackflush_idle_wdata", mem_wdata_o, 32'h55);

    // Reset mid-BUSY abandons the request on the next edge
    @(posedge clk); #1;
    set_ex(EXE_LW_OP, 32'h220, 32'h0, 5'd3, 1'b1, 32'h0);
    ack_after = 0;
    push_bus("rstbusy", 1'b0, 32'h220, 4'b1111, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy_wd",    {27'd0, mem_wd_o}, 32'd0);
    chk("rstbusy_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_ex(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rstbusy_req", {31'd0, dbus_req_o}, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ret_queue_empty", ret_q.size(), 32'd0);
    chk("bus_queue_empty", bus_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
